// File: rtl/pic_mem_stream_reader.sv
// Avalon-MM read master for picture memory port 2: sweeps a block of pixel words
// and re-emits them as a valid/ready stream with SOP/EOP through a small skid FIFO.
module pic_mem_stream_reader #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   num_words_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic              mem_chipselect_o,
    output logic              mem_write_o,
    output logic [1:0]        mem_byteenable_o,
    input  logic [DATA_W-1:0] mem_readdata_i,
    output logic [DATA_W-1:0] pix_data_o,
    output logic              pix_valid_o,
    input  logic              pix_ready_i,
    output logic              pix_sop_o,
    output logic              pix_eop_o
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + READ_LATENCY) + 2;
    localparam int ENT_W = DATA_W + 2;

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN, ST_DONE} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [ADDR_W:0]         remaining_q, remaining_d;
    logic [ADDR_W:0]         num_q, num_d;
    logic [ADDR_W:0]         push_idx_q, push_idx_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [ENT_W-1:0]        fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q, count_d, inflight_s;
    logic [ENT_W-1:0]        head_s, push_ent_s;
    logic                    start_acc_s, credit_ok_s, issue_s, push_s, pop_s, fifo_empty_s;

    // Strobes still travelling through the fixed-latency memory pipe.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight_s = inflight_s + CNT_W'(vld_q[i]);
        end
    end

    assign start_acc_s  = (state_q == ST_IDLE) && start_i;
    // Reads in flight hold a FIFO slot in advance, so a return never finds it full.
    assign credit_ok_s  = (count_q + inflight_s) < CNT_W'(FIFO_DEPTH);
    assign issue_s      = (state_q == ST_FETCH) && credit_ok_s;
    assign push_s       = vld_q[READ_LATENCY-1];
    assign fifo_empty_s = (count_q == '0);
    assign pop_s        = !fifo_empty_s && pix_ready_i;
    assign head_s       = fifo_q[rd_ptr_q];
    assign push_ent_s   = {(push_idx_q == '0), (push_idx_q == num_q - (ADDR_W+1)'(1)), mem_readdata_i};

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_acc_s) state_d = (num_words_i == '0) ? ST_DONE : ST_FETCH;
                else             state_d = ST_IDLE;
            end
            ST_FETCH: begin
                if (issue_s && remaining_q == (ADDR_W+1)'(1)) state_d = ST_DRAIN;
                else                                          state_d = ST_FETCH;
            end
            ST_DRAIN: begin
                if (pop_s && head_s[DATA_W]) state_d = ST_DONE;
                else                         state_d = ST_DRAIN;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from state and datapath registers.
    always_comb begin
        busy_o           = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
        done_o           = (state_q == ST_DONE);
        mem_chipselect_o = issue_s;
        mem_address_o    = addr_q;
        mem_write_o      = 1'b0;
        mem_byteenable_o = 2'b11;
        pix_valid_o      = !fifo_empty_s;
        pix_data_o       = head_s[DATA_W-1:0];
        pix_sop_o        = head_s[DATA_W+1];
        pix_eop_o        = head_s[DATA_W];
    end

    // Address, word counters and read-valid pipe next state.
    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        num_d       = num_q;
        push_idx_d  = push_idx_q;
        if (start_acc_s) begin
            addr_d      = base_addr_i;
            remaining_d = num_words_i;
            num_d       = num_words_i;
            push_idx_d  = '0;
        end else if (issue_s) begin
            addr_d      = addr_q + ADDR_W'(1);
            remaining_d = remaining_q - (ADDR_W+1)'(1);
        end else begin
            addr_d      = addr_q;
        end
        if (push_s) push_idx_d = push_idx_q + (ADDR_W+1)'(1);
        else        push_idx_d = push_idx_d;
        vld_d[0] = issue_s;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            addr_q      <= '0;
            remaining_q <= '0;
            num_q       <= '0;
            push_idx_q  <= '0;
            vld_q       <= '0;
        end else begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            num_q       <= num_d;
            push_idx_q  <= push_idx_d;
            vld_q       <= vld_d;
        end
    end

    always_comb begin
        count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end

    // Skid FIFO storage and pointers; cleared so the stream outputs read 0 after reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_s) begin
                fifo_q[wr_ptr_q] <= push_ent_s;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_pic_mem_stream_reader.sv
// Randomized bench for pic_mem_stream_reader against a frame-level reference model
// (expected beat queue plus issued/accepted word accounting).
module tb_pic_mem_stream_reader;
    localparam int DEPTH = 4096;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, pix_ready = 1'b0;
    logic [11:0] base_addr = '0;
    logic [12:0] num_words = '0;
    logic        busy, done, mem_chipselect, mem_write, pix_valid, pix_sop, pix_eop;
    logic [11:0] mem_address;
    logic [1:0]  mem_byteenable;
    logic [15:0] mem_readdata = '0, pix_data;
    logic [15:0] mem_model [DEPTH];

    pic_mem_stream_reader dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .base_addr_i(base_addr),
        .num_words_i(num_words), .busy_o(busy), .done_o(done),
        .mem_address_o(mem_address), .mem_chipselect_o(mem_chipselect),
        .mem_write_o(mem_write), .mem_byteenable_o(mem_byteenable),
        .mem_readdata_i(mem_readdata), .pix_data_o(pix_data), .pix_valid_o(pix_valid),
        .pix_ready_i(pix_ready), .pix_sop_o(pix_sop), .pix_eop_o(pix_eop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Single-cycle-latency synchronous memory
    always @(posedge clk) if (mem_chipselect) mem_readdata <= mem_model[mem_address];

    int n_checks = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model state
    logic [17:0] exp_q [$];
    int exp_base = 0, exp_n = 0, rd_cnt = 0, beat_cnt = 0, done_cnt = 0;
    int done_cyc = -1, eop_cyc = -1, first_valid_cyc = -1, start_cyc = 0;
    bit saw_stall = 0, prev_stall = 0;
    logic [17:0] prev_word = '0;

    always @(negedge clk) begin
        logic [17:0] w;
        if (!reset) begin
            chk("mem_ctl", {mem_write, mem_byteenable}, 3'b011);
            // Words issued minus words accepted = FIFO occupancy plus reads in flight
            if (busy && rd_cnt < exp_n) chk("cs_credit", mem_chipselect, (rd_cnt - beat_cnt) < 4);
            else                        chk("cs_idle", mem_chipselect, 1'b0);
            if ((rd_cnt - beat_cnt) >= 4 && rd_cnt < exp_n && !mem_chipselect) saw_stall = 1;
            if (mem_chipselect) begin
                chk("addr", mem_address, (exp_base + rd_cnt) % DEPTH);
                rd_cnt++;
            end
            if (prev_stall && pix_valid) chk("hold", {pix_sop, pix_eop, pix_data}, prev_word);
            prev_stall = pix_valid && !pix_ready;
            prev_word  = {pix_sop, pix_eop, pix_data};
            if (pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (pix_valid && pix_ready) begin
                chk("beat_avail", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    chk("beat_word", {pix_sop, pix_eop, pix_data}, w);
                end
                if (pix_eop) eop_cyc = cyc;
                beat_cnt++;
            end
            if (done) begin
                chk("busy_at_done", busy, 1'b0);
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            prev_stall = 0;
        end
    end

    function automatic logic rdy(input int mode, input int t);
        case (mode)
            0:       return 1'b1;
            1:       return (t % 4) == 0;
            2:       return 1'($urandom_range(0, 1));
            default: return $urandom_range(0, 3) != 0;
        endcase
    endfunction

    task automatic setup_model(input int base, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++)
            exp_q.push_back({(i == 0), (i == n - 1), mem_model[(base + i) % DEPTH]});
        exp_base = base; exp_n = n; rd_cnt = 0; beat_cnt = 0; done_cnt = 0;
        done_cyc = -1; eop_cyc = -1; first_valid_cyc = -1; saw_stall = 0;
    endtask

    task automatic run_frame(input int base, input int n, input int mode, input bit restart);
        setup_model(base, n);
        start = 1'b1; base_addr = 12'(base); num_words = 13'(n);
        pix_ready = rdy(mode, 0); start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 1; t < 3000 && done_cnt == 0; t++) begin
            pix_ready = rdy(mode, t);
            if (restart && t == 2) begin
                start = 1'b1; base_addr = 12'($urandom); num_words = 13'($urandom_range(1, 20));
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; pix_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("done_pulses", done_cnt, 1);
        chk("beats", beat_cnt, n);
        chk("reads", rd_cnt, n);
        chk("left_over", exp_q.size(), 0);
        if (n > 0) begin
            chk("done_after_eop", done_cyc - eop_cyc, 1);
            // start cycle, accepting edge, then READ_LATENCY+1 edges to the first beat
            if (mode == 0) chk("first_valid_lat", first_valid_cyc - start_cyc, 3);
        end else begin
            chk("done_n0", done_cyc - start_cyc, 1);
            chk("no_valid_n0", first_valid_cyc, -1);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_cs", mem_chipselect, 1'b0);
        chk("rst_addr", mem_address, 12'h000);
        chk("rst_we", mem_write, 1'b0);
        chk("rst_be", mem_byteenable, 2'b11);
        chk("rst_valid", pix_valid, 1'b0);
        chk("rst_sop", pix_sop, 1'b0);
        chk("rst_eop", pix_eop, 1'b0);
        chk("rst_data", pix_data, 16'h0000);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_model[i] = 16'($urandom);
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b0;
        @(posedge clk); #1;

        run_frame(12'h010, 4, 0, 0);
        run_frame(12'hFFE, 4, 0, 0);
        run_frame(int'($urandom_range(0, DEPTH - 1)), 8, 1, 0);
        chk("stall_seen", saw_stall, 1'b1);
        run_frame(int'($urandom_range(0, DEPTH - 1)), 0, 0, 0);
        run_frame(int'($urandom_range(0, DEPTH - 1)), 8, 0, 1);
        run_frame(int'($urandom_range(0, DEPTH - 1)), 1, 2, 0);

        // Abort a 16-word frame after three reads
        setup_model(12'h123, 16);
        pix_ready = 1'b0; start = 1'b1; base_addr = 12'h123; num_words = 13'd16;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < 50 && rd_cnt < 3; t++) @(negedge clk);
        chk("abort_reads", rd_cnt, 3);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check_reset_outputs();
        @(posedge clk); #1;
        setup_model(0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("abort_no_done", done_cnt, 0);
        run_frame(int'($urandom_range(0, DEPTH - 1)), 2, 0, 0);

        for (int k = 0; k < 12; k++)
            run_frame(int'($urandom_range(DEPTH - 40, DEPTH - 1)) + (k % 2) * 100,
                      int'($urandom_range(1, 40)), int'($urandom_range(0, 3)), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
